// File: rtl/struct_stream_fifo.sv
// ============================================================================
//  Module   : struct_stream_fifo
//  Brief    : Back-pressured first-word-fall-through FIFO carrying {tag, data}.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module struct_stream_fifo #(
  parameter int DATA_W = 8,
  parameter int TAG_W  = 2,
  parameter int DEPTH  = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [DATA_W-1:0]          i_data,
  input  logic [TAG_W-1:0]           i_tag,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [DATA_W-1:0]          o_data,
  output logic [TAG_W-1:0]           o_tag,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = TAG_W + DATA_W;
  localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

  logic [WW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;

  logic [AW:0]   w_count;
  logic          w_push;
  logic          w_pop;
  logic [WW-1:0] w_head;

  // Wrap bit in the MSB makes the modulo difference span 0..DEPTH.
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign o_count = w_count;
  assign o_ready = (w_count != c_DEPTH) & ~i_flush;
  assign o_valid = (w_count != '0);
  assign w_push  = i_valid & o_ready;
  assign w_pop   = o_valid & i_ready;

  assign w_head = o_valid ? r_mem[r_rd_ptr[AW-1:0]] : '0;
  assign o_tag  = w_head[WW-1:DATA_W];
  assign o_data = w_head[DATA_W-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage is never reset; o_valid masks stale contents.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_rst) r_mem[r_wr_ptr[AW-1:0]] <= {i_tag, i_data};
  end

endmodule

`default_nettype wire

// File: tb/tb_struct_stream_fifo.sv
// ============================================================================
//  Module   : tb_struct_stream_fifo
//  Brief    : Directed and scoreboard checks for struct_stream_fifo.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_struct_stream_fifo;

  localparam int DATA_W = 8;
  localparam int TAG_W  = 2;
  localparam int DEPTH  = 4;

  logic                i_clk = 1'b0;
  logic                i_rst, i_flush, i_valid, i_ready;
  logic [DATA_W-1:0]   i_data;
  logic [TAG_W-1:0]    i_tag;
  logic                o_ready, o_valid;
  logic [DATA_W-1:0]   o_data;
  logic [TAG_W-1:0]    o_tag;
  logic [2:0]          o_count;

  int n_vec = 0;
  int n_bad = 0;
  logic [9:0] r_q [$];

  struct_stream_fifo #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data), .i_tag(i_tag),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_tag(o_tag),
    .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic r, input logic [7:0] d,
                       input logic [1:0] t, input logic f);
    i_valid = v; i_ready = r; i_data = d; i_tag = t; i_flush = f;
    #1;
  endtask

  task automatic edge_step();
    @(posedge i_clk);
    #1;
  endtask

  // One cycle against the queue model: check outputs, clock, update model.
  task automatic sb_cycle(input logic v, input logic r, input logic [7:0] d,
                          input logic [1:0] t, input logic f);
    logic ev, er;
    drive(v, r, d, t, f);
    er = (r_q.size() != DEPTH) && !f;
    ev = (r_q.size() != 0);
    check("sb_ready", {31'd0, o_ready}, {31'd0, er});
    check("sb_valid", {31'd0, o_valid}, {31'd0, ev});
    check("sb_count", {29'd0, o_count}, r_q.size());
    if (ev) check("sb_head", {22'd0, o_tag, o_data}, {22'd0, r_q[0]});
    else    check("sb_idle", {22'd0, o_tag, o_data}, 32'd0);
    if (f) r_q.delete();
    else begin
      if (ev && r) void'(r_q.pop_front());
      if (v && er) r_q.push_back({t, d});
    end
    edge_step();
  endtask

  initial begin
    // Reset held two cycles with a beat offered
    i_rst = 1'b1;
    drive(1'b1, 1'b0, 8'h55, 2'd3, 1'b0);
    edge_step();
    edge_step();
    i_rst = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_ready", {31'd0, o_ready}, 32'd1);
    check("rst_count", {29'd0, o_count}, 32'd0);
    check("rst_data",  {24'd0, o_data},  32'd0);
    check("rst_tag",   {30'd0, o_tag},   32'd0);

    // Single beat, one-cycle latency
    drive(1'b1, 1'b0, 8'hFF, 2'd1, 1'b0);
    check("one_pre_valid", {31'd0, o_valid}, 32'd0);
    edge_step();
    drive(1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
    check("one_valid", {31'd0, o_valid}, 32'd1);
    check("one_data",  {24'd0, o_data},  32'hFF);
    check("one_tag",   {30'd0, o_tag},   32'd1);
    check("one_count", {29'd0, o_count}, 32'd1);
    drive(1'b0, 1'b1, 8'h00, 2'd0, 1'b0);
    edge_step();
    check("one_popped", {31'd0, o_valid}, 32'd0);

    // Fill to DEPTH, hold off the fifth beat
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b0, 8'(i), 2'(i), 1'b0);
      edge_step();
    end
    drive(1'b1, 1'b0, 8'h05, 2'd1, 1'b0);
    check("full_count", {29'd0, o_count}, 32'd4);
    check("full_ready", {31'd0, o_ready}, 32'd0);
    edge_step();
    drive(1'b1, 1'b1, 8'h05, 2'd1, 1'b0);
    check("full_hold_count", {29'd0, o_count}, 32'd4);
    check("full_ready_pop",  {31'd0, o_ready}, 32'd0);
    check("drain_01", {24'd0, o_data}, 32'h01);
    edge_step();
    drive(1'b1, 1'b0, 8'h05, 2'd1, 1'b0);
    check("after_pop_count", {29'd0, o_count}, 32'd3);
    check("after_pop_ready", {31'd0, o_ready}, 32'd1);
    edge_step();
    check("refill_count", {29'd0, o_count}, 32'd4);
    for (int i = 2; i <= 5; i++) begin
      drive(1'b0, 1'b1, 8'h00, 2'd0, 1'b0);
      check("drain_data", {24'd0, o_data}, i);
      check("drain_tag",  {30'd0, o_tag},  i % 4);
      edge_step();
    end
    check("drain_empty", {31'd0, o_valid}, 32'd0);

    // Streaming across several pointer wraps
    for (int i = 0; i < 20; i++) sb_cycle(1'b1, 1'b1, 8'(8'h10 + i), 2'(i), 1'b0);
    while (r_q.size() != 0) sb_cycle(1'b0, 1'b1, 8'h00, 2'd0, 1'b0);

    // Flush discards stored beats and refuses the offered one
    for (int i = 0; i < 3; i++) sb_cycle(1'b1, 1'b0, 8'(8'h30 + i), 2'(i), 1'b0);
    sb_cycle(1'b1, 1'b0, 8'hAA, 2'd2, 1'b1);
    sb_cycle(1'b1, 1'b0, 8'hBB, 2'd3, 1'b0);
    sb_cycle(1'b0, 1'b1, 8'h00, 2'd0, 1'b0);
    sb_cycle(1'b0, 1'b1, 8'h00, 2'd0, 1'b0);

    // Random traffic against the queue model
    for (int i = 0; i < 300; i++)
      sb_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
               8'($urandom), 2'($urandom), $urandom_range(0, 40) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
